// File: rtl/div_pkg.sv
// Shared definitions for the iterative 32-bit divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int          DIV_ITER   = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit_32_step.sv
// One restoring-division step: trial subtract, keep on non-negative, restore otherwise.
module div_step_33 (
    input  logic [32:0] rem_in,
    input  logic [31:0] dvs,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [32:0] trial;

    // Subtract at 33 bits so the sign bit tells us whether the divisor fit.
    always_comb begin
        trial   = rem_in - {1'b0, dvs};
        q_bit   = ~trial[32];
        rem_out = q_bit ? trial : rem_in;
    end

endmodule

// File: rtl/div_unit_32.sv
// Multi-cycle DIV/DIVU unit: magnitudes are divided by restoring iteration,
// then signs are fixed up. Quotient feeds LO, remainder feeds HI.
module div_unit_32
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             s,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_e       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [WIDTH-1:0] a_q, a_d;         // original dividend, returned on divide-by-zero
    logic             qsign_q, qsign_d;
    logic             dsign_q, dsign_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dzo_q, dzo_d;

    logic [2*WIDTH:0] sh;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    // {remainder, dividend} shifted left by one; the top 33 bits feed the step.
    assign sh = {rem_q, dvd_q} << 1;

    div_step_33 u_step (
        .rem_in  (sh[2*WIDTH:WIDTH]),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Next-state, datapath and sign-fix logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        qsign_d = qsign_q;
        dsign_d = dsign_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dzo_d   = dzo_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (start) begin
                    // Sign flags are pre-gated with s so FIX needs no mode check.
                    dsign_d = s & A[WIDTH-1];
                    qsign_d = s & (A[WIDTH-1] ^ B[WIDTH-1]);
                    dvd_d   = (s && A[WIDTH-1]) ? -A : A;
                    dvs_d   = (s && B[WIDTH-1]) ? -B : B;
                    a_d     = A;
                    dz_d    = (B == '0);
                    rem_d   = '0;
                    cnt_d   = 5'(DIV_ITER - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, step_q};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    quot_d = DIV_ZERO_Q;
                    remo_d = a_q;
                end else begin
                    quot_d = qsign_q ? -dvd_q : dvd_q;
                    remo_d = dsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
                dzo_d   = dz_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            qsign_q <= 1'b0;
            dsign_q <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            qsign_q <= qsign_d;
            dsign_q <= dsign_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dzo_q   <= dzo_d;
        end
    end

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign div_zero  = dzo_q;

endmodule
